// File: rtl/bch_enc_block_if.sv
// Purpose: handshake bundle for bch_enc_block (message in, codeword out, status).
// Latency: n/a (wiring only); the encoder adds 7 cycles from accept to out_valid.
// Backpressure: valid/ready on both sides; slave = encoder, master = its user.
// Signals: in_valid/in_ready/msg (message side), out_valid/out_ready/codeword
//          (codeword side), busy (status), err_mask (only with BCH_ENC_ERR_INJECT_EN).
interface bch_enc_block_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  msg;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] codeword;
    logic        busy;
`ifdef BCH_ENC_ERR_INJECT_EN
    logic [14:0] err_mask;
`endif

    modport slave (
        input  in_valid,
        input  msg,
        input  out_ready,
`ifdef BCH_ENC_ERR_INJECT_EN
        input  err_mask,
`endif
        output in_ready,
        output out_valid,
        output codeword,
        output busy
    );

    modport master (
        output in_valid,
        output msg,
        output out_ready,
`ifdef BCH_ENC_ERR_INJECT_EN
        output err_mask,
`endif
        input  in_ready,
        input  out_valid,
        input  codeword,
        input  busy
    );
endinterface

// File: rtl/bch_enc_block.sv
// Purpose: serial LFSR encoder for systematic BCH(15,7); codeword = {msg, (msg*x^8) mod g(x)}.
// Latency: 7 cycles from the accepting edge to out_valid; 9 cycles minimum per codeword.
// Backpressure: codeword held in DONE until out_ready; in_ready only in IDLE, so input stalls.
// Ports: clk, rst (synchronous, active high), bus (bch_enc_block_if.slave).
// Optional: define BCH_ENC_ERR_INJECT_EN to add err_mask, XORed into the emitted codeword.
// GEN_POLY: bit i is the x^i coefficient of g(x); bit 8 must be 1 and is implied by the shift.
module bch_enc_block #(
    parameter logic [8:0] GEN_POLY = 9'h1D1
) (
    input  logic              clk,
    input  logic              rst,
    bch_enc_block_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [6:0]  msg_r;
    logic [7:0]  par;
    logic [2:0]  cnt;
    logic [14:0] code_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic        busy_r;
`ifdef BCH_ENC_ERR_INJECT_EN
    logic [14:0] err_mask_r;
`endif

    // One step of polynomial division, message MSB first.
    logic       fb;
    logic [7:0] par_nxt;
    logic [14:0] code_nxt;

    always_comb begin
        fb       = msg_r[cnt] ^ par[7];
        par_nxt  = {par[6:0], 1'b0} ^ (fb ? GEN_POLY[7:0] : 8'h00);
`ifdef BCH_ENC_ERR_INJECT_EN
        code_nxt = {msg_r, par_nxt} ^ err_mask_r;
`else
        code_nxt = {msg_r, par_nxt};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            msg_r       <= 7'h00;
            par         <= 8'h00;
            cnt         <= 3'd0;
            code_r      <= 15'h0000;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef BCH_ENC_ERR_INJECT_EN
            err_mask_r  <= 15'h0000;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is implied by being in IDLE.
                    if (bus.in_valid) begin
                        msg_r      <= bus.msg;
                        par        <= 8'h00;
                        cnt        <= 3'd6;
                        state      <= SHIFT;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
`ifdef BCH_ENC_ERR_INJECT_EN
                        err_mask_r <= bus.err_mask;
`endif
                    end
                end
                SHIFT: begin
                    par <= par_nxt;
                    if (cnt == 3'd0) begin
                        // Capture the parity from this final step, not the stale register.
                        code_r      <= code_nxt;
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.codeword  = code_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_bch_enc_block.sv
// Purpose: directed self-checking bench for bch_enc_block (reset, vectors, backpressure, stream, reset abort).
// Latency: expects out_valid on the 7th cycle after the accepting edge, 9-cycle streaming period.
// Backpressure: holds out_ready low for 20 cycles and checks the codeword and in_ready are held.
module tb_bch_enc_block;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bch_enc_block_if bus ();

    bch_enc_block #(.GEN_POLY(9'h1D1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // x^(8+i) mod g(x), worked out by hand for g = x^8+x^7+x^6+x^4+1.
    function automatic logic [14:0] ref_enc(input logic [6:0] m);
        logic [7:0] tbl [7];
        logic [7:0] p;
        tbl = '{8'hD1, 8'h73, 8'hE6, 8'h1D, 8'h3A, 8'h74, 8'hE8};
        p = 8'h00;
        for (int i = 0; i < 7; i++)
            if (m[i]) p = p ^ tbl[i];
        return {m, p};
    endfunction

    // Syndromes S1,S2,S3 over GF(16) with primitive polynomial x^4+x+1.
    function automatic logic [11:0] syndromes(input logic [14:0] c);
        logic [3:0] a [15];
        logic [3:0] s [3];
        a[0] = 4'h1;
        for (int i = 1; i < 15; i++)
            a[i] = a[i-1][3] ? ({a[i-1][2:0], 1'b0} ^ 4'h3) : {a[i-1][2:0], 1'b0};
        for (int j = 0; j < 3; j++) begin
            s[j] = 4'h0;
            for (int i = 0; i < 15; i++)
                if (c[i]) s[j] = s[j] ^ a[(i * (j + 1)) % 15];
        end
        return {s[0], s[1], s[2]};
    endfunction

    // Starts just after a negedge; returns just after the negedge following the accept edge.
    task automatic send(input logic [6:0] m, input bit keep_valid, output int t_acc);
        int n;
        bus.msg = m;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(bus.in_ready), 32'd1);
        t_acc = cyc;
        @(negedge clk);
        if (!keep_valid) bus.in_valid = 1'b0;
    endtask

    task automatic wait_ov(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 40);
        chk("out_valid_seen", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic encode(input string tag, input logic [6:0] m, input logic [14:0] exp);
        int t, lat;
        send(m, 1'b0, t);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
        wait_ov(lat);
        chk({tag, "_latency"}, 32'(lat), 32'd7);
        chk({tag, "_codeword"}, 32'(bus.codeword), 32'(exp));
    endtask

    initial begin
        int t, tprev, lat, seen;
        logic [14:0] hold;

        bus.in_valid  = 1'b0;
        bus.msg       = 7'h00;
        bus.out_ready = 1'b1;
`ifdef BCH_ENC_ERR_INJECT_EN
        bus.err_mask  = 15'h0000;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_codeword",  32'(bus.codeword),  32'h0000);

        // Directed vectors.
        encode("msg01", 7'h01, 15'h01D1);
        @(negedge clk);
        chk("msg01_idle_after", 32'(bus.in_ready), 32'd1);
        chk("msg01_cw_kept",    32'(bus.codeword), 32'h01D1);
        encode("msg40", 7'h40, 15'h40E8);
        @(negedge clk);
        encode("msg7f", 7'h7F, 15'h7FFF);
        @(negedge clk);
        encode("msg00", 7'h00, 15'h0000);
        @(negedge clk);

        // Backpressure: codeword and in_ready held while in_valid and msg keep moving.
        bus.out_ready = 1'b0;
        encode("bp_msg7f", 7'h7F, 15'h7FFF);
        hold = bus.codeword;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.msg = 7'(i) ^ 7'h2A;
            @(negedge clk);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
            chk("bp_codeword",  32'(bus.codeword),  32'h7FFF);
        end
        bus.msg = 7'h40;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
        chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_cw_kept",   32'(bus.codeword),  32'(hold));
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp_next_accepted", 32'(bus.busy), 32'd1);
        wait_ov(lat);
        chk("bp_next_latency",  32'(lat), 32'd7);
        chk("bp_next_codeword", 32'(bus.codeword), 32'h40E8);
        @(negedge clk);

        // Streaming with in_valid and out_ready held high.
        tprev = 0;
        for (int m = 0; m < 128; m++) begin
            send(7'(m), 1'b1, t);
            if (m > 0) chk("stream_period", 32'(t - tprev), 32'd9);
            tprev = t;
            if (m < 127) bus.msg = 7'(m + 1);
            wait_ov(lat);
            chk("stream_codeword",  32'(bus.codeword), 32'(ref_enc(7'(m))));
            chk("stream_syndromes", 32'(syndromes(bus.codeword)), 32'h0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Reset at shift edge E4 discards the message.
        send(7'h7F, 1'b0, t);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_codeword",  32'(bus.codeword),  32'h0000);
        chk("abort_busy",      32'(bus.busy),      32'd0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("abort_no_out_valid", 32'(seen), 32'd0);
        encode("abort_msg01", 7'h01, 15'h01D1);
        @(negedge clk);

`ifdef BCH_ENC_ERR_INJECT_EN
        bus.err_mask = 15'h4001;
        encode("inj_msg01", 7'h01, 15'h41D0);
        chk("inj_corrected", 32'(bus.codeword ^ 15'h4001), 32'h01D1);
        bus.err_mask = 15'h0000;
        @(negedge clk);
        encode("inj_clear", 7'h01, 15'h01D1);
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bch_enc_block.md
# bch_enc_block

Serial LFSR encoder for the systematic BCH(15,7) double-error-correcting code over GF(16). It is the transmit-side counterpart of the syndrome / Berlekamp-Massey / Chien decode chain. Handshakes:
- Accepts a 7-bit message on a valid/ready input.
- Divides it by the generator polynomial over 7 clock cycles.
- Presents the 15-bit codeword on a valid/ready output until it is taken.

## Interface
- GEN_POLY, default 9'h1D1: generator g(x) = x^8+x^7+x^6+x^4+1. Bit i is the coefficient of x^i; bit 8 must be 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset. Sampled only on the rising edge of clk.
- in_valid  input  1  message available.
- in_ready  output  1  encoder can accept a message (IDLE only).
- msg  input  7  message; msg[6] is the x^14 coefficient.
- out_valid  output  1  codeword valid.
- out_ready  input  1  downstream accepts codeword.
- codeword  output  15  systematic codeword {msg, parity}; bit i is the coefficient of x^i.
- busy  output  1  high in SHIFT or DONE.
- err_mask  input  15  present only with BCH_ENC_ERR_INJECT_EN; see Configuration.

## Operation
- FSM states: IDLE, SHIFT, DONE. Encoding is 2 bits.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, codeword=0, parity=0, cnt=0.
- IDLE, when in_valid && in_ready at an edge:
  - msg_r <= msg, par <= 0, cnt <= 6, state <= SHIFT.
- SHIFT, each edge:
  - fb = msg_r[cnt] ^ par[7].
  - par <= {par[6:0],1'b0} ^ (fb ? GEN_POLY[7:0] : 8'h00).
  - If cnt==0: state <= DONE and codeword <= {msg_r, next par}. Otherwise cnt <= cnt-1.
- DONE: out_valid=1. When out_ready is high at an edge, state <= IDLE.
- Result: parity = (msg·x^8) mod g(x). codeword[14:8]=msg, codeword[7:0]=parity.
- Arithmetic is GF(2) only: XOR, no carries. cnt is 3 bits and never wraps below 0.
- in_ready=1 only in IDLE. in_valid is ignored in SHIFT and DONE, and msg is not re-sampled there.
- codeword and out_valid are registered. codeword is stable for the whole time out_valid=1 and keeps its last value after the handshake.
- rst asserted in any state returns all registers to reset values at that edge. An in-flight message is discarded and no partial codeword is emitted.
- Back-to-back: out_ready=1 on DONE entry gives a 1-cycle DONE. The next message can be accepted on the following edge.

## Timing
- Accept edge E0; shift edges E1..E7; out_valid=1 in the cycle after E7. Latency is 7 cycles from the accepting edge to out_valid.
- Minimum period per codeword is 9 cycles: 1 accept + 7 shift + 1 DONE.
- No combinational path from in_valid to in_ready or from out_ready to out_valid. Ready and valid are decoded from the state register only.
- out_valid stays high indefinitely under backpressure (out_ready=0). in_ready stays 0 throughout.

## Configuration
- BCH_ENC_ERR_INJECT_EN defined:
  - Port err_mask[14:0] exists. It is sampled into a register on the accepting edge together with msg.
  - The DONE codeword is {msg_r, par} ^ err_mask_r. This lets benches and on-chip self-test corrupt up to 15 bits for the decoder chain.
  - busy and timing are unchanged.
- BCH_ENC_ERR_INJECT_EN undefined: err_mask port and register are absent, and codeword is always the clean codeword.

## Test plan
- Reset, then msg=7'h01 with in_valid pulse -> out_valid 7 cycles after accept, codeword=15'h01D1.
- msg=7'h40 -> codeword=15'h40E8. msg=7'h7F -> 15'h7FFF. msg=7'h00 -> 15'h0000.
- Backpressure: out_ready=0 for 20 cycles after out_valid, with in_valid=1 and msg toggling.
  - Required: codeword held, in_ready=0, no second accept.
  - Release out_ready: IDLE next cycle, and the new msg is accepted on the following edge.
- Streaming with in_valid and out_ready tied high over msg=0..127 -> one codeword every 9 cycles. Every codeword passes the software model, and the syndromes S1=S2=S3=0 in the decoder chain.
- rst asserted at shift edge E4, then released -> in_ready=1, out_valid=0, codeword=0, and no out_valid pulse follows. A subsequent msg=7'h01 still gives 15'h01D1.
- With BCH_ENC_ERR_INJECT_EN: msg=7'h01, err_mask=15'h4001 -> codeword=15'h41D0. Feeding this into the decoder chain recovers 15'h01D1.
